// File: rtl/tm1638_pkg.sv
// Shared command bytes and state encodings for the TM1638 display/key scheduler.
package tm1638_pkg;
  localparam logic [7:0] CMD_DATA_WRITE = 8'h40;
  localparam logic [7:0] CMD_DATA_READ  = 8'h42;
  localparam logic [7:0] CMD_ADDR_BASE  = 8'hC0;
  localparam logic [7:0] CMD_DISP_CTRL  = 8'h80;
  localparam int         RAM_DEPTH      = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_STB_LO, S_ISSUE, S_WAIT, S_TURN, S_RD, S_RD_WAIT, S_STB_HI
  } state_t;

  typedef enum logic [1:0] {T_MODE, T_DATA, T_CTRL, T_SCAN} txn_t;
endpackage

// File: rtl/tm1638_sched_timer.sv
// Free-running key-scan period counter; o_expire is high for the one cycle the count sits at zero.
module tm1638_sched_timer #(
  parameter int PERIOD = 120000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_expire
);
  localparam int            CW     = $clog2(PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign o_expire = (cnt == '0);
endmodule

// File: rtl/tm1638_scheduler.sv
// Sequences TM1638 command windows (mode, address+data, display control, key read) over the byte engine.
// Engine handshake: a request is a 1-cycle pulse raised only while i_eng_idle is high; it is done once i_eng_idle is high again after the cycle following the pulse.
module tm1638_scheduler
  import tm1638_pkg::*;
#(
  parameter int CLOCK_FREQ_MHz = 12,
  parameter int STB_GAP_CYCLES = 12,
  parameter int SCAN_PERIOD    = 120000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ram_we,
  input  logic [3:0] i_ram_addr,
  input  logic [7:0] i_ram_data,
  input  logic [2:0] i_brightness,
  input  logic       i_display_on,
  input  logic       i_refresh,
  output logic [7:0] o_keys,
  output logic       o_keys_valid,
  output logic       o_busy,
  output logic       o_stb,
  output logic       o_eng_write_en,
  output logic [7:0] o_eng_raw_data,
  output logic       o_eng_read_en,
  input  logic [7:0] i_eng_btn_state,
  input  logic       i_eng_idle
);
  // The STB gap must never be shorter than 1 us of system clock.
  localparam int            GAP      = (STB_GAP_CYCLES < CLOCK_FREQ_MHz) ? CLOCK_FREQ_MHz : STB_GAP_CYCLES;
  localparam int            GW       = $clog2(GAP + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  logic [7:0]    ram [RAM_DEPTH];
  state_t        state;
  txn_t          txn;
  logic [4:0]    byte_idx;
  logic [GW-1:0] gap_cnt;
  logic          wait_first;
  logic          cont;
  logic          dirty;
  logic          scan_pend;
  logic [3:0]    ctrl_shadow;
  logic          scan_expire;
  logic          gap_done;
  logic          more_bytes;
  logic          dirty_set;
  logic          mode_issue;
  logic [7:0]    cmd_byte;
  logic [7:0]    ram_rd;

  tm1638_sched_timer #(.PERIOD(SCAN_PERIOD)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .o_expire (scan_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_ram_we) ram[i_ram_addr] <= i_ram_data;
  end

  // byte_idx still names the byte just sent, so this is RAM[next byte_idx - 1].
  assign ram_rd     = ram[byte_idx[3:0]];
  assign gap_done   = (gap_cnt == GAP_LAST);
  assign more_bytes = (txn == T_DATA) && (byte_idx < 5'd16);
  assign dirty_set  = i_ram_we || i_refresh || ({i_display_on, i_brightness} != ctrl_shadow);
  assign mode_issue = (state == S_ISSUE) && i_eng_idle && (txn == T_MODE);

  always_comb begin
    cmd_byte = CMD_DATA_READ;
    case (txn)
      T_MODE:  cmd_byte = CMD_DATA_WRITE;
      T_DATA:  cmd_byte = CMD_ADDR_BASE;
      T_CTRL:  cmd_byte = CMD_DISP_CTRL | {4'b0000, ctrl_shadow};
      default: cmd_byte = CMD_DATA_READ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      txn            <= T_MODE;
      byte_idx       <= '0;
      gap_cnt        <= '0;
      wait_first     <= 1'b0;
      cont           <= 1'b0;
      dirty          <= 1'b1;
      scan_pend      <= 1'b0;
      ctrl_shadow    <= '0;
      o_stb          <= 1'b1;
      o_eng_write_en <= 1'b0;
      o_eng_read_en  <= 1'b0;
      o_eng_raw_data <= '0;
      o_keys         <= '0;
      o_keys_valid   <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_eng_write_en <= 1'b0;
      o_eng_read_en  <= 1'b0;
      o_keys_valid   <= 1'b0;
      ctrl_shadow    <= {i_display_on, i_brightness};
      // A write landing on the mode-issue cycle keeps dirty set: that data may miss this frame.
      if (dirty_set) dirty <= 1'b1;
      else if (mode_issue) dirty <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_eng_idle && (cont || scan_pend || dirty)) begin
            state    <= S_STB_LO;
            o_stb    <= 1'b0;
            o_busy   <= 1'b1;
            gap_cnt  <= '0;
            byte_idx <= '0;
            if (!cont) begin
              if (scan_pend) begin
                txn       <= T_SCAN;
                scan_pend <= 1'b0;
              end else begin
                txn <= T_MODE;
              end
            end
          end
        end
        S_STB_LO: begin
          if (gap_done) begin
            state          <= S_ISSUE;
            o_eng_raw_data <= cmd_byte;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        S_ISSUE: begin
          if (i_eng_idle) begin
            o_eng_write_en <= 1'b1;
            wait_first     <= 1'b1;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (i_eng_idle) begin
            gap_cnt <= '0;
            if (more_bytes) begin
              byte_idx       <= byte_idx + 5'd1;
              o_eng_raw_data <= ram_rd;
              state          <= S_ISSUE;
            end else if (txn == T_SCAN) begin
              state <= S_TURN;
            end else begin
              o_stb <= 1'b1;
              state <= S_STB_HI;
            end
          end
        end
        S_TURN: begin
          if (gap_done) state <= S_RD;
          else gap_cnt <= gap_cnt + GW'(1);
        end
        S_RD: begin
          if (i_eng_idle) begin
            o_eng_read_en <= 1'b1;
            wait_first    <= 1'b1;
            state         <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (i_eng_idle) begin
            o_keys       <= i_eng_btn_state;
            o_keys_valid <= 1'b1;
            o_stb        <= 1'b1;
            gap_cnt      <= '0;
            state        <= S_STB_HI;
          end
        end
        S_STB_HI: begin
          if (gap_done) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            cont   <= (txn == T_MODE) || (txn == T_DATA);
            if (txn == T_MODE) txn <= T_DATA;
            else if (txn == T_DATA) txn <= T_CTRL;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      // Placed last so an expiry on the scan-start cycle is not lost.
      if (scan_expire) scan_pend <= 1'b1;
    end
  end
endmodule

// File: tb/tb_tm1638_scheduler.sv
// Directed bench for tm1638_scheduler with a behavioural byte engine and an STB-window logger.
module tb_tm1638_scheduler;
  localparam int MHZ   = 4;
  localparam int GAP   = 4;
  localparam int P     = 1500;
  localparam int ENG_N = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ram_we = 1'b0;
  logic [3:0] ram_addr = '0;
  logic [7:0] ram_data = '0;
  logic [2:0] brightness = '0;
  logic       display_on = 1'b0;
  logic       refresh = 1'b0;
  logic [7:0] keys;
  logic       keys_valid;
  logic       busy;
  logic       stb;
  logic       eng_write_en;
  logic [7:0] eng_raw_data;
  logic       eng_read_en;
  logic [7:0] model_keys = 8'h00;
  logic       eng_idle;

  tm1638_scheduler #(
    .CLOCK_FREQ_MHz (MHZ),
    .STB_GAP_CYCLES (GAP),
    .SCAN_PERIOD    (P)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_ram_we        (ram_we),
    .i_ram_addr      (ram_addr),
    .i_ram_data      (ram_data),
    .i_brightness    (brightness),
    .i_display_on    (display_on),
    .i_refresh       (refresh),
    .o_keys          (keys),
    .o_keys_valid    (keys_valid),
    .o_busy          (busy),
    .o_stb           (stb),
    .o_eng_write_en  (eng_write_en),
    .o_eng_raw_data  (eng_raw_data),
    .o_eng_read_en   (eng_read_en),
    .i_eng_btn_state (model_keys),
    .i_eng_idle      (eng_idle)
  );

  // behavioural engine: not reset, busy ENG_N cycles after each request
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (eng_write_en || eng_read_en) busy_cnt <= ENG_N;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign eng_idle = (busy_cnt == 0) && !eng_write_en && !eng_read_en;

  // STB window logger
  logic [7:0] byte_log[$];
  int win_off[$], win_len[$], win_reads[$], win_start[$], win_end[$];
  int rel_cyc = 0, cur_len = 0, cur_reads = 0, cur_start = 0;
  int last_wr = 0, read_gap = 0, valid_cnt = 0, req_viol = 0, stb_viol = 0;
  bit in_win = 1'b0;
  logic stb_prev = 1'b1;
  logic [7:0] keys_seen = '0;

  always @(negedge clk) begin
    if (!rst_n) rel_cyc = 0;
    else rel_cyc++;
    if (stb_prev && !stb) begin
      in_win = 1'b1; cur_len = 0; cur_reads = 0; cur_start = rel_cyc;
      win_off.push_back(byte_log.size());
      if (busy_cnt != 0) stb_viol++;
    end
    if (eng_write_en) begin
      byte_log.push_back(eng_raw_data);
      cur_len++;
      last_wr = rel_cyc;
      if (stb) req_viol++;
    end
    if (eng_read_en) begin
      cur_reads++;
      read_gap = rel_cyc - last_wr;
      if (stb) req_viol++;
    end
    if ((eng_write_en || eng_read_en) && busy_cnt != 0) req_viol++;
    if (keys_valid) begin
      valid_cnt++;
      keys_seen = keys;
    end
    if (!stb_prev && stb && in_win) begin
      in_win = 1'b0;
      win_len.push_back(cur_len);
      win_reads.push_back(cur_reads);
      win_start.push_back(cur_start);
      win_end.push_back(rel_cyc);
    end
    stb_prev = stb;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ram_exp [16];
  logic [7:0] ram_old [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input int w, input logic [7:0] ctrl, input logic [7:0] r [16],
                             input string tag);
    int off;
    exp_q.delete();
    exp_q.push_back(8'h40);
    exp_q.push_back(8'hC0);
    for (int i = 0; i < 16; i++) exp_q.push_back(r[i]);
    exp_q.push_back(ctrl);
    chk({tag, "_mode_len"}, win_len[w], 1);
    chk({tag, "_data_len"}, win_len[w+1], 17);
    chk({tag, "_ctrl_len"}, win_len[w+2], 1);
    chk({tag, "_reads"}, win_reads[w] + win_reads[w+1] + win_reads[w+2], 0);
    off = win_off[w];
    for (int k = 0; k < 19; k++) begin
      chk($sformatf("%s_byte%0d", tag, k), byte_log[off+k], exp_q.pop_front());
    end
  endtask

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_wins(input int n, input int budget, input string tag);
    int t = 0;
    while (win_len.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_wait_windows"}, win_len.size() >= n, 1);
  endtask

  task automatic ram_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    ram_we = 1'b1; ram_addr = a; ram_data = d;
    @(negedge clk);
    ram_we = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  initial begin
    int n0, n1, t, exp_rel;

    // reset with the RAM preloaded so the init frame is known
    wait_cycles(2);
    for (int i = 0; i < 16; i++) begin
      ram_exp[i] = 8'(i * 19 + 7);
      ram_write(4'(i), ram_exp[i]);
    end
    wait_cycles(1);
    chk("rst_stb", stb, 1'b1);
    chk("rst_write_en", eng_write_en, 1'b0);
    chk("rst_read_en", eng_read_en, 1'b0);
    chk("rst_raw_data", eng_raw_data, 8'h00);
    chk("rst_keys", keys, 8'h00);
    chk("rst_keys_valid", keys_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    // 1: init frame
    wait_wins(3, 1000, "t1");
    check_frame(0, 8'h80, ram_exp, "t1");
    chk("t1_write_pulses", byte_log.size(), 19);
    wait_cycles(50);
    chk("t1_window_count", win_len.size(), 3);

    // 2: RAM write plus display control change in one cycle -> one frame
    @(negedge clk);
    brightness = 3'd7; display_on = 1'b1;
    ram_we = 1'b1; ram_addr = 4'd3; ram_data = 8'hA5;
    @(negedge clk);
    ram_we = 1'b0;
    ram_exp[3] = 8'hA5;
    wait_wins(6, 1000, "t2");
    check_frame(3, 8'h8F, ram_exp, "t2");
    chk("t2_digit3", byte_log[win_off[4] + 4], 8'hA5);
    wait_cycles(100);
    chk("t2_window_count", win_len.size(), 6);

    // 3: periodic key scan
    model_keys = 8'h81;
    wait_wins(7, 2 * P, "t3");
    chk("t3_scan_cmd", byte_log[win_off[6]], 8'h42);
    chk("t3_scan_len", win_len[6], 1);
    chk("t3_scan_reads", win_reads[6], 1);
    chk("t3_turn_gap_ok", read_gap >= ENG_N + GAP, 1'b1);
    wait_cycles(5);
    chk("t3_valid_cycles", valid_cnt, 1);
    chk("t3_keys_at_valid", keys_seen, 8'h81);
    chk("t3_keys_held", keys, 8'h81);

    // 4: scan expiry lands inside T_DATA
    n0 = win_len.size();
    t = 0;
    while ((rel_cyc % P) != P - 100 && t < 2 * P) begin
      @(negedge clk);
      t++;
    end
    chk("t4_phase_found", t < 2 * P, 1'b1);
    exp_rel = rel_cyc + 100;
    pulse_refresh();
    wait_wins(n0 + 4, 1500, "t4");
    check_frame(n0, 8'h8F, ram_exp, "t4");
    chk("t4_expiry_in_data", (win_start[n0+1] < exp_rel) && (exp_rel < win_end[n0+1]), 1'b1);
    chk("t4_scan_cmd", byte_log[win_off[n0+3]], 8'h42);
    chk("t4_scan_reads", win_reads[n0+3], 1);
    wait_cycles(200);
    chk("t4_window_count", win_len.size(), n0 + 4);
    chk("t4_valid_cycles", valid_cnt, 2);

    // 5: RAM write mid-T_DATA -> exactly one extra frame
    n0 = win_len.size();
    pulse_refresh();
    t = 0;
    while (!(win_len.size() == n0 + 1 && in_win && cur_len >= 8) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("t5_mid_data_found", t < 500, 1'b1);
    ram_old = ram_exp;
    ram_write(4'd5, 8'h3C);
    ram_exp[5] = 8'h3C;
    wait_wins(n0 + 6, 1500, "t5");
    check_frame(n0, 8'h8F, ram_old, "t5a");
    check_frame(n0 + 3, 8'h8F, ram_exp, "t5b");
    wait_cycles(300);
    chk("t5_window_count", win_len.size(), n0 + 6);

    // 6: reset while the engine is shifting a byte
    n0 = win_len.size();
    pulse_refresh();
    t = 0;
    while (!(win_len.size() == n0 + 1 && in_win && cur_len >= 3) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("t6_mid_byte_found", t < 500, 1'b1);
    chk("t6_engine_busy", busy_cnt != 0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_stb_after_reset", stb, 1'b1);
    chk("t6_busy_after_reset", busy, 1'b0);
    chk("t6_write_after_reset", eng_write_en, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    n1 = win_len.size();
    chk("t6_partial_closed", n1, n0 + 2);
    wait_wins(n1 + 3, 1000, "t6");
    check_frame(n1, 8'h8F, ram_exp, "t6");
    chk("t6_req_while_busy", req_viol, 0);
    chk("t6_stb_while_busy", stb_viol, 0);

    wait_cycles(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
